// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - CPU/DMA/memory bus bundle for the data-memory arbiter
interface dmem_arbiter_if #(
   parameter int XLEN = 32
);
   // CPU requester
   logic            cpu_req;
   logic            cpu_we;
   logic [XLEN-1:0] cpu_addr;
   logic [XLEN-1:0] cpu_wdata;
   logic [3:0]      cpu_be;
   logic            cpu_gnt;
   logic            cpu_stall;
   logic            cpu_rvalid;
   logic [XLEN-1:0] cpu_rdata;

   // DMA requester
   logic            dma_req;
   logic            dma_we;
   logic [XLEN-1:0] dma_addr;
   logic [XLEN-1:0] dma_wdata;
   logic [3:0]      dma_be;
   logic            dma_gnt;
   logic            dma_rvalid;
   logic [XLEN-1:0] dma_rdata;

   // Memory side
   logic            mem_en;
   logic            mem_we;
   logic [XLEN-1:0] mem_addr;
   logic [XLEN-1:0] mem_wdata;
   logic [3:0]      mem_be;
   logic [XLEN-1:0] mem_rdata;

   // Arbiter view
   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
      output cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
      input  dma_req, dma_we, dma_addr, dma_wdata, dma_be,
      output dma_gnt, dma_rvalid, dma_rdata,
      output mem_en, mem_we, mem_addr, mem_wdata, mem_be,
      input  mem_rdata
   );

   // Requester/memory environment view
   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
      input  cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
      output dma_req, dma_we, dma_addr, dma_wdata, dma_be,
      input  dma_gnt, dma_rvalid, dma_rdata,
      input  mem_en, mem_we, mem_addr, mem_wdata, mem_be,
      output mem_rdata
   );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - CPU/DMA data-memory arbiter; DMEM_ARB_RR_EN selects round-robin
module dmem_arbiter #(
   parameter int XLEN     = 32,
   parameter int MAX_WAIT = 8
) (
   input logic            clk,
   input logic            rst,
   dmem_arbiter_if.slave  bus
);
   localparam logic       PORT_CPU   = 1'b0;
   localparam logic       PORT_DMA   = 1'b1;
   localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

   logic [7:0]      wait_cnt;
   logic            last_gnt;
   logic            rd_valid;
   logic            rd_owner;

   logic            dma_wins;
   logic            cpu_gnt;
   logic            dma_gnt;
   logic            mem_we_int;
   logic [XLEN-1:0] sel_addr;
   logic [XLEN-1:0] sel_wdata;
   logic [3:0]      sel_be;
   logic            cpu_rvalid;
   logic            dma_rvalid;

   // Contention tie-break: who takes the slot when both ports request
   always_comb begin
`ifdef DMEM_ARB_RR_EN
      dma_wins = (last_gnt == PORT_CPU);
`else
      dma_wins = (wait_cnt == MAX_WAIT_C);
`endif
   end

   // Same-cycle grant; reset blocks every grant so pending requests re-arbitrate afterwards
   always_comb begin
      cpu_gnt = 1'b0;
      dma_gnt = 1'b0;
      if (!rst) begin
         cpu_gnt = bus.cpu_req && !(bus.dma_req && dma_wins);
         dma_gnt = bus.dma_req && (!bus.cpu_req || dma_wins);
      end
   end

   // Route the granted port onto the memory bus; idle bus is driven to zero
   always_comb begin
      mem_we_int = 1'b0;
      sel_addr   = '0;
      sel_wdata  = '0;
      sel_be     = 4'h0;
      if (cpu_gnt) begin
         mem_we_int = bus.cpu_we;
         sel_addr   = bus.cpu_addr;
         sel_wdata  = bus.cpu_wdata;
         sel_be     = bus.cpu_be;
      end else if (dma_gnt) begin
         mem_we_int = bus.dma_we;
         sel_addr   = bus.dma_addr;
         sel_wdata  = bus.dma_wdata;
         sel_be     = bus.dma_be;
      end
   end

   // Wait counter, last-grant record and one-deep read-owner register
   always_ff @(posedge clk) begin
      if (rst) begin
         wait_cnt <= 8'h00;
         last_gnt <= PORT_DMA;
         rd_valid <= 1'b0;
         rd_owner <= PORT_CPU;
      end else begin
`ifdef DMEM_ARB_RR_EN
         wait_cnt <= 8'h00;
`else
         if (!bus.dma_req || dma_gnt)
            wait_cnt <= 8'h00;
         else if (wait_cnt != MAX_WAIT_C)
            wait_cnt <= wait_cnt + 8'h01;
`endif
         if (cpu_gnt)
            last_gnt <= PORT_CPU;
         else if (dma_gnt)
            last_gnt <= PORT_DMA;
         rd_valid <= (cpu_gnt || dma_gnt) && !mem_we_int;
         rd_owner <= dma_gnt ? PORT_DMA : PORT_CPU;
      end
   end

   // Read response steering; a reset in the response cycle swallows it
   always_comb begin
      cpu_rvalid = rd_valid && (rd_owner == PORT_CPU) && !rst;
      dma_rvalid = rd_valid && (rd_owner == PORT_DMA) && !rst;
   end

   assign bus.cpu_gnt    = cpu_gnt;
   assign bus.dma_gnt    = dma_gnt;
   assign bus.cpu_stall  = bus.cpu_req && !cpu_gnt && !rst;
   assign bus.mem_en     = cpu_gnt || dma_gnt;
   assign bus.mem_we     = mem_we_int;
   assign bus.mem_addr   = sel_addr;
   assign bus.mem_wdata  = sel_wdata;
   assign bus.mem_be     = sel_be;
   assign bus.cpu_rvalid = cpu_rvalid;
   assign bus.dma_rvalid = dma_rvalid;
   assign bus.cpu_rdata  = cpu_rvalid ? bus.mem_rdata : '0;
   assign bus.dma_rdata  = dma_rvalid ? bus.mem_rdata : '0;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - randomized model-checked bench for dmem_arbiter
module tb_dmem_arbiter;
   localparam int XLEN     = 32;
   localparam int MAX_WAIT = 8;
   localparam int NONE = 0, CPU = 1, DMA = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   dmem_arbiter_if #(.XLEN(XLEN)) bus ();

   dmem_arbiter #(.XLEN(XLEN), .MAX_WAIT(MAX_WAIT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model state: starvation count, last granted port, pending read owner
   int m_wait = 0;
   int m_last = DMA;
   int m_pend = NONE;

   // Per-cycle comparison against the behavioural model
   always @(negedge clk) begin
      int win;
      bit dma_pref;
      logic            e_we;
      logic [XLEN-1:0] e_addr, e_wdata;
      logic [3:0]      e_be;
      bit              e_crv, e_drv;
`ifdef DMEM_ARB_RR_EN
      dma_pref = (m_last == CPU);
`else
      dma_pref = (m_wait == MAX_WAIT);
`endif
      if (rst) win = NONE;
      else if (bus.cpu_req && bus.dma_req) win = dma_pref ? DMA : CPU;
      else if (bus.cpu_req) win = CPU;
      else if (bus.dma_req) win = DMA;
      else win = NONE;
      e_we = 0; e_addr = 0; e_wdata = 0; e_be = 0;
      if (win == CPU) begin
         e_we = bus.cpu_we; e_addr = bus.cpu_addr; e_wdata = bus.cpu_wdata; e_be = bus.cpu_be;
      end else if (win == DMA) begin
         e_we = bus.dma_we; e_addr = bus.dma_addr; e_wdata = bus.dma_wdata; e_be = bus.dma_be;
      end
      e_crv = !rst && m_pend == CPU;
      e_drv = !rst && m_pend == DMA;
      chk("cpu_gnt",    bus.cpu_gnt,   64'(win == CPU));
      chk("dma_gnt",    bus.dma_gnt,   64'(win == DMA));
      chk("cpu_stall",  bus.cpu_stall, 64'(!rst && bus.cpu_req && win != CPU));
      chk("mem_en",     bus.mem_en,    64'(win != NONE));
      chk("mem_we",     bus.mem_we,    64'(e_we));
      chk("mem_be",     bus.mem_be,    64'(e_be));
      chk("mem_addr",   bus.mem_addr,  64'(e_addr));
      chk("mem_wdata",  bus.mem_wdata, 64'(e_wdata));
      chk("cpu_rvalid", bus.cpu_rvalid, 64'(e_crv));
      chk("dma_rvalid", bus.dma_rvalid, 64'(e_drv));
      chk("cpu_rdata",  bus.cpu_rdata, e_crv ? 64'(bus.mem_rdata) : 64'h0);
      chk("dma_rdata",  bus.dma_rdata, e_drv ? 64'(bus.mem_rdata) : 64'h0);
      chk("wait_cnt",   dut.wait_cnt,  64'(m_wait));
      chk("last_gnt",   dut.last_gnt,  64'(m_last == DMA));
      // advance the model to the next cycle
      if (rst) begin
         m_wait = 0; m_last = DMA; m_pend = NONE;
      end else begin
`ifdef DMEM_ARB_RR_EN
         m_wait = 0;
`else
         if (bus.dma_req && win != DMA) m_wait = (m_wait < MAX_WAIT) ? m_wait + 1 : MAX_WAIT;
         else m_wait = 0;
`endif
         if (win != NONE) m_last = win;
         m_pend = (win != NONE && !e_we) ? win : NONE;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic new_cpu();
      bus.cpu_req   = ($urandom_range(0, 99) < 70);
      bus.cpu_we    = $urandom_range(0, 1);
      bus.cpu_addr  = $urandom;
      bus.cpu_wdata = $urandom;
      bus.cpu_be    = 4'($urandom_range(0, 15));
   endtask

   task automatic new_dma();
      bus.dma_req   = ($urandom_range(0, 99) < 60);
      bus.dma_we    = $urandom_range(0, 1);
      bus.dma_addr  = $urandom;
      bus.dma_wdata = $urandom;
      bus.dma_be    = 4'($urandom_range(0, 15));
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic cg, dg;
      bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0; bus.cpu_be = 4'hF;
      bus.dma_req = 1; bus.dma_we = 0; bus.dma_addr = 0; bus.dma_wdata = 0; bus.dma_be = 4'hF;
      bus.mem_rdata = 0;
      rst = 1;
      tick(); tick();
      @(negedge clk);
      chk("rst cpu_gnt", bus.cpu_gnt, 0);
      chk("rst dma_gnt", bus.dma_gnt, 0);
      chk("rst cpu_stall", bus.cpu_stall, 0);
      chk("rst mem_en", bus.mem_en, 0);
      chk("rst wait_cnt", dut.wait_cnt, 0);
      chk("rst last_gnt", dut.last_gnt, 1);
      tick();

      // lone CPU read
      rst = 0; bus.dma_req = 0;
      bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 32'h100;
      @(negedge clk);
      chk("lone cpu_gnt", bus.cpu_gnt, 1);
      chk("lone mem_addr", bus.mem_addr, 32'h100);
      tick();
      bus.cpu_req = 0; bus.mem_rdata = 32'hDEADBEEF;
      @(negedge clk);
      chk("lone cpu_rvalid", bus.cpu_rvalid, 1);
      chk("lone cpu_rdata", bus.cpu_rdata, 32'hDEADBEEF);
      chk("lone dma_rvalid", bus.dma_rvalid, 0);
      tick();

      // idle cycles
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("idle mem_en", bus.mem_en, 0);
         chk("idle mem_be", bus.mem_be, 0);
         chk("idle mem_addr", bus.mem_addr, 0);
         chk("idle last_gnt", dut.last_gnt, 0);
         tick();
      end

      // DMA byte write
      bus.dma_req = 1; bus.dma_we = 1; bus.dma_be = 4'h4; bus.dma_addr = 32'h20; bus.dma_wdata = 32'h55AA;
      @(negedge clk);
      chk("dmaw dma_gnt", bus.dma_gnt, 1);
      chk("dmaw mem_en", bus.mem_en, 1);
      chk("dmaw mem_we", bus.mem_we, 1);
      chk("dmaw mem_be", bus.mem_be, 4'h4);
      chk("dmaw mem_addr", bus.mem_addr, 32'h20);
      tick();
      bus.dma_req = 0;
      @(negedge clk);
      chk("dmaw cpu_rvalid", bus.cpu_rvalid, 0);
      chk("dmaw dma_rvalid", bus.dma_rvalid, 0);
      tick();

      // continuous contention from reset
      rst = 1; tick(); rst = 0;
      bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 32'h40;
      bus.dma_req = 1; bus.dma_we = 0; bus.dma_addr = 32'h80;
`ifdef DMEM_ARB_RR_EN
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("rr cpu_gnt", bus.cpu_gnt, 64'(c % 2 == 0));
         chk("rr dma_gnt", bus.dma_gnt, 64'(c % 2 == 1));
         chk("rr cpu_stall", bus.cpu_stall, 64'(c % 2 == 1));
         tick();
      end
`else
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         chk("fix cpu_gnt", bus.cpu_gnt, 64'(c != 8));
         chk("fix dma_gnt", bus.dma_gnt, 64'(c == 8));
         if (c == 9) chk("fix wait_cnt", dut.wait_cnt, 0);
         tick();
      end
`endif
      bus.cpu_req = 0; bus.dma_req = 0;

      // reset right after a CPU read grant
      bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 32'h104;
      @(negedge clk);
      chk("rstrd cpu_gnt", bus.cpu_gnt, 1);
      tick();
      rst = 1; bus.cpu_req = 0;
      @(negedge clk);
      chk("rstrd cpu_rvalid", bus.cpu_rvalid, 0);
      chk("rstrd cpu_gnt0", bus.cpu_gnt, 0);
      chk("rstrd dma_gnt0", bus.dma_gnt, 0);
      tick();
      @(negedge clk);
      chk("rstrd wait_cnt", dut.wait_cnt, 0);
      tick();
      rst = 0;

      // randomized traffic; pending requests mostly held until granted
      cg = 0; dg = 0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         cg = bus.cpu_gnt; dg = bus.dma_gnt;
         tick();
         rst = ($urandom_range(0, 199) == 0);
         bus.mem_rdata = $urandom;
         if (!(bus.cpu_req && !cg && $urandom_range(0, 19) != 0)) new_cpu();
         if (!(bus.dma_req && !dg && $urandom_range(0, 19) != 0)) new_dma();
      end
      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
